// File: rtl/vpm_pipe_ctrl_if.sv
// Valid/ready/data stream bundle used at both ends of the pipeline.
// The master drives valid and data; the slave answers with ready.
interface vpm_pipe_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/vpm_pipe_ctrl.sv
// Parametrised N-stage data pipeline with per-stage valid, hazard stall and
// flush. Stage 0 is the input side, stage DEPTH-1 drives the output.
// Backpressure only holds occupied stages, so bubbles are squeezed out.
// A flush of stage k squashes stage k and every stage upstream of it.
module vpm_pipe_ctrl #(
  parameter int DEPTH      = 5,
  parameter int WIDTH      = 8,
  parameter int RESET_DATA = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  vpm_pipe_ctrl_if.slave               up,
  vpm_pipe_ctrl_if.master              dn,
  input  logic [DEPTH-1:0]             stall,
  input  logic [DEPTH-1:0]             flush,
  output logic [DEPTH-1:0]             stage_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] kill;
  logic [DEPTH-1:0] src_valid;
  logic [DEPTH-1:0] load;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             flush_any;
  logic             in_ready;

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [WIDTH-1:0] data_d     [DEPTH];

  // Hold and kill chains, walked from the output end towards the input.
  // hold collapses through empty stages; kill accumulates downstream flushes.
  always_comb begin
    logic h_acc;
    logic k_acc;
    h_acc = ~dn.ready;
    k_acc = 1'b0;
    hold  = '0;
    kill  = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      h_acc   = valid_q[i] & (stall[i] | h_acc);
      k_acc   = k_acc | flush[i];
      hold[i] = h_acc;
      kill[i] = k_acc;
    end
  end

  // Input acceptance never looks at in_valid, so there is no
  // combinational in_valid -> in_ready path; any flush blocks input so
  // nothing accepted can be squashed in the same cycle.
  always_comb begin
    flush_any = |flush;
    in_ready  = ~hold[0] & ~flush_any;
  end

  // Per-stage next state: kill beats hold, hold beats advance.
  // A stalled stage keeps its item, so the stage after it receives a
  // bubble instead of a copy. Data only loads when a real item arrives.
  always_comb begin
    src_valid    = '0;
    load         = '0;
    valid_d      = '0;
    src_valid[0] = up.valid & in_ready;
    for (int i = 1; i < DEPTH; i++) begin
      src_valid[i] = valid_q[i-1] & ~flush[i-1] & ~hold[i-1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (kill[i]) begin
        valid_d[i] = 1'b0;
      end else if (hold[i]) begin
        valid_d[i] = valid_q[i];
      end else begin
        valid_d[i] = src_valid[i];
      end
      load[i] = ~kill[i] & ~hold[i] & src_valid[i];
    end
    data_d[0] = load[0] ? up.data : stage_data[0];
    for (int i = 1; i < DEPTH; i++) begin
      data_d[i] = load[i] ? stage_data[i-1] : stage_data[i];
    end
  end

  // Occupancy of the next-state valid vector, registered with it.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  // Valid bits and occupancy counter always clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Data registers, one per stage; reset is optional to allow plain
  // enable-flops when the payload needs no defined reset value.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] data_q;

    if (RESET_DATA != 0) begin : g_rst
      // Stage payload register with asynchronous clear.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_q <= '0;
        end else begin
          data_q <= data_d[gi];
        end
      end
    end else begin : g_nrst
      // Stage payload register without reset.
      always_ff @(posedge clk) begin
        data_q <= data_d[gi];
      end
    end

    assign stage_data[gi] = data_q;
  end

  assign up.ready    = in_ready;
  assign dn.valid    = valid_q[DEPTH-1] & ~flush[DEPTH-1];
  assign dn.data     = stage_data[DEPTH-1];
  assign stage_valid = valid_q;
  assign count       = count_q;

endmodule

// File: tb/tb_vpm_pipe_ctrl.sv
// Self-checking bench for vpm_pipe_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// slot-occupancy model of the pipeline.
module tb_vpm_pipe_ctrl;
  localparam int D  = 5;
  localparam int W  = 8;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst;
  logic [D-1:0]  stall;
  logic [D-1:0]  flush;
  logic [D-1:0]  stage_valid;
  logic [CW-1:0] count;

  vpm_pipe_ctrl_if #(.WIDTH(W)) up_if ();
  vpm_pipe_ctrl_if #(.WIDTH(W)) dn_if ();

  vpm_pipe_ctrl #(.DEPTH(D), .WIDTH(W), .RESET_DATA(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .up          (up_if),
    .dn          (dn_if),
    .stall       (stall),
    .flush       (flush),
    .stage_valid (stage_valid),
    .count       (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  bit verbose  = 1'b1;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_occ[k]/m_dat[k]: item sitting in slot k. An item moves on when its
  // slot is not stalled and there is room ahead (empty slot, or the slot
  // ahead is itself moving, or the output is taking it).
  logic [D-1:0] m_occ = '0;
  logic [W-1:0] m_dat [D];

  function automatic logic [D-1:0] moving();
    logic [D-1:0] g;
    bit room;
    room = dn_if.ready;
    for (int k = D-1; k >= 0; k--) begin
      g[k] = m_occ[k] && !stall[k] && room;
      room = !m_occ[k] || g[k];
    end
    return g;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [D-1:0] g;
    logic [D-1:0] n_occ;
    logic [W-1:0] n_dat [D];
    bit killed;
    bit acc;
    bit mv;
    if (rst) begin
      m_occ <= '0;
    end else begin
      g      = moving();
      acc    = up_if.valid && (!m_occ[0] || g[0]) && (flush == '0);
      killed = 0;
      for (int k = D-1; k >= 0; k--) begin
        killed   = killed || flush[k];
        n_dat[k] = m_dat[k];
        if (killed) begin
          n_occ[k] = 1'b0;
        end else if (m_occ[k] && !g[k]) begin
          n_occ[k] = 1'b1;
        end else if (k == 0) begin
          n_occ[k] = acc;
          if (acc) n_dat[k] = up_if.data;
        end else begin
          mv       = m_occ[k-1] && g[k-1] && !flush[k-1];
          n_occ[k] = mv;
          if (mv) n_dat[k] = m_dat[k-1];
        end
      end
      m_occ <= n_occ;
      m_dat <= n_dat;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [D-1:0] g;
    bit e_in_ready;
    bit e_out_valid;
    g           = moving();
    e_in_ready  = (!m_occ[0] || g[0]) && (flush == '0);
    e_out_valid = m_occ[D-1] && !flush[D-1];
    chk("cyc_stage_valid", stage_valid, m_occ);
    chk("cyc_count", count, $countones(m_occ));
    chk("cyc_in_ready", up_if.ready, e_in_ready);
    chk("cyc_out_valid", dn_if.valid, e_out_valid);
    if (e_out_valid) chk("cyc_out_data", dn_if.data, m_dat[D-1]);
  end

  // ---------------- output transfer log ----------------
  typedef struct {
    logic [W-1:0] d;
    int           c;
  } xfer_t;
  xfer_t outs[$];

  always @(negedge clk) begin
    if (!rst && dn_if.valid && dn_if.ready) begin
      outs.push_back('{dn_if.data, cyc_n});
      if (verbose) $display("out  data=%02h cycle=%0d", dn_if.data, cyc_n);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, output int acc_cyc);
    bit ok;
    ok      = 0;
    acc_cyc = -1;
    up_if.valid = 1'b1;
    up_if.data  = d;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (up_if.ready) begin
        ok      = 1;
        acc_cyc = cyc_n;
      end
      cyc();
    end
    up_if.valid = 1'b0;
    if (verbose && ok) $display("in   data=%02h cycle=%0d", d, acc_cyc);
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done;
    done        = 0;
    dn_if.ready = 1'b1;
    stall       = '0;
    flush       = '0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (stage_valid == '0) done = 1;
      cyc();
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_outs(input string name, input logic [W-1:0] exp[$], input bit consec);
    chk({name, "_n"}, outs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < outs.size(); i++) begin
      chk({name, "_data"}, outs[i].d, exp[i]);
      if (consec) chk({name, "_cycle"}, outs[i].c, outs[0].c + i);
    end
  endtask

  task automatic fill(input logic [W-1:0] base);
    int a;
    dn_if.ready = 1'b0;
    for (int i = 0; i < D; i++) send(base + W'(i), a);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int a0;
    logic [W-1:0] exp[$];

    rst         = 1'b1;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b1;
    stall       = '0;
    flush       = '0;
    #2;
    chk("rst_stage_valid", stage_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_out_valid", dn_if.valid, 0);
    chk("rst_in_ready", up_if.ready, 1);
    chk("rst_out_data", dn_if.data, 0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // Stream 0x01..0x0A back-to-back
    outs.delete();
    a0 = 0;
    for (int i = 1; i <= 10; i++) begin
      send(W'(i), a);
      if (i == 1) a0 = a;
      if (i == 7) chk("stream_count", count, 5);
    end
    drain();
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    expect_outs("stream", exp, 1);
    if (outs.size() > 0) chk("stream_latency", outs[0].c - a0, 5);

    // Backpressure
    outs.delete();
    fill(8'h10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", up_if.ready, 0);
      chk("bp_out_valid", dn_if.valid, 1);
      chk("bp_out_data", dn_if.data, 8'h10);
      chk("bp_count", count, 5);
      cyc();
    end
    drain();
    exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    expect_outs("bp", exp, 1);

    // Bubble collapse with stage 4 stalled
    outs.delete();
    dn_if.ready = 1'b0;
    stall       = 5'b10000;
    send(8'h21, a);
    cyc();
    cyc();
    send(8'h22, a);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bubble_in_ready", up_if.ready, 1);
      cyc();
    end
    chk("bubble_stage_valid", stage_valid, 5'b11000);
    chk("bubble_count", count, 2);
    chk("bubble_out_data", dn_if.data, 8'h21);
    drain();
    exp = '{8'h21, 8'h22};
    expect_outs("bubble", exp, 0);

    // Flush of stage 2 on a full pipe
    fill(8'h30);
    outs.delete();
    flush = 5'b00100;
    @(negedge clk);
    chk("flush_in_ready", up_if.ready, 0);
    cyc();
    flush = '0;
    chk("flush_stage_valid", stage_valid, 5'b11000);
    chk("flush_count", count, 2);
    drain();
    exp = '{8'h30, 8'h31};
    expect_outs("flush", exp, 0);

    // Stall of stage 1 together with flush of stage 3
    fill(8'h40);
    outs.delete();
    stall = 5'b00010;
    flush = 5'b01000;
    cyc();
    stall = '0;
    flush = '0;
    chk("fvs_stage_valid", stage_valid, 5'b10000);
    chk("fvs_out_data", dn_if.data, 8'h40);
    drain();
    exp = '{8'h40};
    expect_outs("fvs", exp, 0);

    // Asynchronous reset mid-stream
    dn_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'h60 + W'(i), a);
    up_if.valid = 1'b1;
    up_if.data  = 8'h64;
    #3;
    rst = 1'b1;
    up_if.valid = 1'b0;
    #1;
    chk("arst_stage_valid", stage_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_out_valid", dn_if.valid, 0);
    chk("arst_in_ready", up_if.ready, 1);
    cyc();
    cyc();
    rst = 1'b0;
    outs.delete();
    send(8'h55, a);
    drain();
    exp = '{8'h55};
    expect_outs("arst", exp, 0);
    if (outs.size() > 0) chk("arst_latency", outs[0].c - a, 5);

    // Randomized traffic, checked every cycle by the compare process
    verbose = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      up_if.valid = ($urandom_range(0, 3) != 0);
      up_if.data  = W'($urandom);
      dn_if.ready = ($urandom_range(0, 3) != 0);
      stall       = D'($urandom & $urandom & $urandom);
      flush       = ($urandom_range(0, 15) == 0) ? D'(1 << $urandom_range(0, D-1)) : '0;
      if (i == 1500) begin
        #2;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
      cyc();
    end
    up_if.valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
